// File: rtl/mmu_pkg.sv
// Shared definitions for the translation controller and its TLB/STLB/PMU neighbours:
// state encoding, derived address-field widths and fault codes.
package mmu_pkg;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      L1    = 4'd1,
      L2    = 4'd2,
      WREQ  = 4'd3,
      WWAIT = 4'd4,
      FILL2 = 4'd5,
      FILL1 = 4'd6,
      RESP  = 4'd7,
      DRAIN = 4'd8
   } xlate_state_e;

   localparam logic [1:0] FAULT_NONE   = 2'd0;
   localparam logic [1:0] FAULT_PAGE   = 2'd1;
   localparam logic [1:0] FAULT_ACCESS = 2'd2;

   function automatic int vpn_width(input int va_w, input int page_shift);
      return va_w - page_shift;
   endfunction

   function automatic int ppn_width(input int pa_w, input int page_shift);
      return pa_w - page_shift;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Enable-driven statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/mmu_xlate_ctrl.sv
// L1 TLB / STLB miss-handling controller: probes L1, then STLB, then the page-table walker,
// refills both levels inclusively and returns {ppn, offset} or a fault.
module mmu_xlate_ctrl
   import mmu_pkg::*;
#(
   parameter int VA_W       = 64,
   parameter int PA_W       = 64,
   parameter int PCID_W     = 12,
   parameter int PAGE_SHIFT = 12,
   parameter int CNT_W      = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic [VA_W-1:0]            i_req_va,
   input  logic [PCID_W-1:0]          i_req_pcid,
   output logic                       o_rsp_valid,
   input  logic                       i_rsp_ready,
   output logic [PA_W-1:0]            o_rsp_pa,
   output logic                       o_rsp_fault,
   output logic                       o_l1_lookup,
   output logic [VA_W-PAGE_SHIFT-1:0] o_l1_vpn,
   output logic [PCID_W-1:0]          o_l1_pcid,
   input  logic                       i_l1_hit,
   input  logic [PA_W-PAGE_SHIFT-1:0] i_l1_ppn,
   output logic                       o_l1_fill,
   output logic [PA_W-PAGE_SHIFT-1:0] o_l1_fill_ppn,
   output logic                       o_l2_lookup,
   input  logic                       i_l2_hit,
   input  logic [PA_W-PAGE_SHIFT-1:0] i_l2_ppn,
   output logic                       o_l2_fill,
   output logic [PA_W-PAGE_SHIFT-1:0] o_l2_fill_ppn,
   output logic                       o_ptw_req_valid,
   input  logic                       i_ptw_req_ready,
   input  logic                       i_ptw_rsp_valid,
   input  logic [PA_W-PAGE_SHIFT-1:0] i_ptw_rsp_ppn,
   input  logic                       i_ptw_rsp_fault,
   input  logic                       i_flush,
   output logic [CNT_W-1:0]           o_cnt_l1_hit,
   output logic [CNT_W-1:0]           o_cnt_l2_hit,
   output logic [CNT_W-1:0]           o_cnt_walk,
   output logic [CNT_W-1:0]           o_cnt_fault
);

   localparam int VPN_W = vpn_width(VA_W, PAGE_SHIFT);
   localparam int PPN_W = ppn_width(PA_W, PAGE_SHIFT);

   localparam logic [3:0] S_IDLE  = IDLE;
   localparam logic [3:0] S_L1    = L1;
   localparam logic [3:0] S_L2    = L2;
   localparam logic [3:0] S_WREQ  = WREQ;
   localparam logic [3:0] S_WWAIT = WWAIT;
   localparam logic [3:0] S_FILL2 = FILL2;
   localparam logic [3:0] S_FILL1 = FILL1;
   localparam logic [3:0] S_RESP  = RESP;
   localparam logic [3:0] S_DRAIN = DRAIN;

   logic [3:0]            r_state;
   logic [3:0]            w_state_nxt;
   logic [VPN_W-1:0]      r_vpn;
   logic [PAGE_SHIFT-1:0] r_off;
   logic [PCID_W-1:0]     r_pcid;
   logic [PPN_W-1:0]      r_ppn;
   logic [PA_W-1:0]       r_rsp_pa;
   logic                  r_rsp_fault;

   logic w_accept;
   logic w_inc_l1;
   logic w_inc_l2;
   logic w_inc_walk;
   logic w_inc_fault;

   assign w_accept    = i_req_valid && o_req_ready;
   assign w_inc_l1    = (r_state == S_L1) && i_l1_hit && !i_flush;
   assign w_inc_l2    = (r_state == S_L2) && i_l2_hit && !i_flush;
   // The walker has taken the request even if a flush lands in the same cycle.
   assign w_inc_walk  = (r_state == S_WREQ) && i_ptw_req_ready;
   assign w_inc_fault = (r_state == S_WWAIT) && i_ptw_rsp_valid && i_ptw_rsp_fault && !i_flush;

   always_comb begin
      w_state_nxt = r_state;
      if (i_flush) begin
         case (r_state)
            S_WWAIT: w_state_nxt = i_ptw_rsp_valid ? S_IDLE : S_DRAIN;
            S_WREQ:  w_state_nxt = i_ptw_req_ready ? S_DRAIN : S_IDLE;
            // A walk is still outstanding; keep waiting for it to retire.
            S_DRAIN: w_state_nxt = i_ptw_rsp_valid ? S_IDLE : S_DRAIN;
            default: w_state_nxt = S_IDLE;
         endcase
      end else begin
         case (r_state)
            S_IDLE:  w_state_nxt = i_req_valid ? S_L1 : S_IDLE;
            S_L1:    w_state_nxt = i_l1_hit ? S_RESP : S_L2;
            S_L2:    w_state_nxt = i_l2_hit ? S_FILL1 : S_WREQ;
            S_WREQ:  w_state_nxt = i_ptw_req_ready ? S_WWAIT : S_WREQ;
            S_WWAIT: begin
               if (i_ptw_rsp_valid) begin
                  w_state_nxt = i_ptw_rsp_fault ? S_RESP : S_FILL2;
               end else begin
                  w_state_nxt = S_WWAIT;
               end
            end
            S_FILL2: w_state_nxt = S_FILL1;
            S_FILL1: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = i_rsp_ready ? S_IDLE : S_RESP;
            S_DRAIN: w_state_nxt = i_ptw_rsp_valid ? S_IDLE : S_DRAIN;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_vpn       <= '0;
         r_off       <= '0;
         r_pcid      <= '0;
         r_ppn       <= '0;
         r_rsp_pa    <= '0;
         r_rsp_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_vpn  <= i_req_va[VA_W-1:PAGE_SHIFT];
            r_off  <= i_req_va[PAGE_SHIFT-1:0];
            r_pcid <= i_req_pcid;
         end
         if (i_flush) begin
            r_rsp_fault <= 1'b0;
         end else begin
            case (r_state)
               S_L1: begin
                  if (i_l1_hit) begin
                     r_rsp_pa    <= {i_l1_ppn, r_off};
                     r_rsp_fault <= 1'b0;
                  end
               end
               S_L2: begin
                  if (i_l2_hit) begin
                     r_ppn <= i_l2_ppn;
                  end
               end
               S_WWAIT: begin
                  if (i_ptw_rsp_valid && i_ptw_rsp_fault) begin
                     r_rsp_pa    <= '0;
                     r_rsp_fault <= 1'b1;
                  end else if (i_ptw_rsp_valid) begin
                     r_ppn <= i_ptw_rsp_ppn;
                  end
               end
               S_FILL1: begin
                  r_rsp_pa    <= {r_ppn, r_off};
                  r_rsp_fault <= 1'b0;
               end
               S_RESP: begin
                  if (i_rsp_ready) begin
                     r_rsp_fault <= 1'b0;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign o_req_ready     = (r_state == S_IDLE) && !i_flush;
   assign o_rsp_valid     = (r_state == S_RESP);
   assign o_rsp_pa        = r_rsp_pa;
   assign o_rsp_fault     = r_rsp_fault;
   assign o_l1_lookup     = (r_state == S_L1);
   assign o_l2_lookup     = (r_state == S_L2);
   assign o_l1_vpn        = r_vpn;
   assign o_l1_pcid       = r_pcid;
   assign o_l1_fill       = (r_state == S_FILL1) && !i_flush;
   assign o_l2_fill       = (r_state == S_FILL2) && !i_flush;
   assign o_l1_fill_ppn   = r_ppn;
   assign o_l2_fill_ppn   = r_ppn;
   assign o_ptw_req_valid = (r_state == S_WREQ);

   sat_counter #(.CNT_W(CNT_W)) u_cnt_l1_hit (
      .clk(clk), .rst_n(rst_n), .i_en(w_inc_l1), .o_cnt(o_cnt_l1_hit)
   );
   sat_counter #(.CNT_W(CNT_W)) u_cnt_l2_hit (
      .clk(clk), .rst_n(rst_n), .i_en(w_inc_l2), .o_cnt(o_cnt_l2_hit)
   );
   sat_counter #(.CNT_W(CNT_W)) u_cnt_walk (
      .clk(clk), .rst_n(rst_n), .i_en(w_inc_walk), .o_cnt(o_cnt_walk)
   );
   sat_counter #(.CNT_W(CNT_W)) u_cnt_fault (
      .clk(clk), .rst_n(rst_n), .i_en(w_inc_fault), .o_cnt(o_cnt_fault)
   );

endmodule
